// File: rtl/descrambler58bit_order58_rx.sv
// Receive-side descrambler for the 58-bit, order-58 frame scrambler (Si = Di ~^ Si-39 ~^ Si-58).
// Tracks history trust, per-word corruption, link lock and a saturating corrupted-word counter.
module descrambler58bit_order58_rx #(
  parameter logic [57:0] INIT_SEED     = 58'h112abaa1231ba11,
  parameter int unsigned LOCK_WORDS    = 4,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [57:0]              data,
  input  logic                     enable,
  input  logic                     data_error,
  input  logic                     bypass,
  input  logic                     err_count_clear,
  output logic [57:0]              descrambledData,
  output logic                     descrambled_valid,
  output logic                     descrambled_error,
  output logic                     locked,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  localparam int W   = 58;
  localparam int TAP = 39;
  localparam logic [7:0] LOCK_CNT = 8'(LOCK_WORDS);

  typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2} lock_e;

  typedef struct packed {
    logic [W-1:0] data;
    logic         valid;
    logic         error;
  } out_t;

  out_t                     out_q, out_d;
  logic [W-1:0]             prev_q, prev_d;
  logic [W-1:0]             desc_w;
  logic                     hist_ok_q, hist_ok_d;
  logic                     word_err;
  logic [7:0]               good_q, good_d;
  lock_e                    state_q, state_d;
  logic                     locked_q, locked_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Taps 39 back land in the current word for the upper bits, in the previous word otherwise.
  genvar g;
  generate
    for (g = 0; g < W; g++) begin : g_bit
      if (g >= TAP) begin : g_hi
        assign desc_w[g] = data[g] ~^ data[g-TAP] ~^ prev_q[g];
      end else begin : g_lo
        assign desc_w[g] = data[g] ~^ prev_q[g+W-TAP] ~^ prev_q[g];
      end
    end
  endgenerate

  // An untrusted history only matters when actually descrambling.
  assign word_err = data_error | (~bypass & ~hist_ok_q);

  always_comb begin
    out_d       = out_q;
    out_d.valid = 1'b0;
    prev_d      = prev_q;
    hist_ok_d   = hist_ok_q;
    if (enable) begin
      out_d.data  = bypass ? data : desc_w;
      out_d.valid = 1'b1;
      out_d.error = word_err;
      prev_d      = data;
      hist_ok_d   = ~data_error;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (enable) begin
      if (word_err) begin
        state_d = UNLOCKED;
        good_d  = '0;
      end else if (!bypass) begin
        if (good_q < LOCK_CNT) good_d = good_q + 8'd1;
        state_d = (good_d >= LOCK_CNT) ? LOCKED : LOCKING;
      end
    end
    locked_d = (state_d == LOCKED);
  end

  // Clear wins over a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (err_count_clear) cnt_d = '0;
    else if (enable && word_err && !(&cnt_q)) cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      prev_q    <= INIT_SEED;
      hist_ok_q <= 1'b0;
      good_q    <= '0;
      state_q   <= UNLOCKED;
      locked_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      out_q     <= out_d;
      prev_q    <= prev_d;
      hist_ok_q <= hist_ok_d;
      good_q    <= good_d;
      state_q   <= state_d;
      locked_q  <= locked_d;
      cnt_q     <= cnt_d;
    end
  end

  assign descrambledData   = out_q.data;
  assign descrambled_valid = out_q.valid;
  assign descrambled_error = out_q.error;
  assign locked            = locked_q;
  assign err_count         = cnt_q;

endmodule

// File: tb/tb_descrambler58bit_order58_rx.sv
// Randomized bench: a bit-serial transmit scrambler and a word-level receive model predict every output.
module tb_descrambler58bit_order58_rx;
  localparam logic [57:0] SEED = 58'h112abaa1231ba11;
  localparam int LW = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [57:0] data = '0;
  logic        enable = 1'b0, data_error = 1'b0, bypass = 1'b0, err_count_clear = 1'b0;
  logic [57:0] descrambledData, dd_s;
  logic        descrambled_valid, descrambled_error, locked;
  logic        dv_s, de_s, lk_s;
  logic [15:0] err_count;
  logic [3:0]  err_count_s;

  descrambler58bit_order58_rx #(.INIT_SEED(SEED), .LOCK_WORDS(LW), .ERR_CNT_WIDTH(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .data(data), .enable(enable), .data_error(data_error),
    .bypass(bypass), .err_count_clear(err_count_clear), .descrambledData(descrambledData),
    .descrambled_valid(descrambled_valid), .descrambled_error(descrambled_error),
    .locked(locked), .err_count(err_count));

  descrambler58bit_order58_rx #(.INIT_SEED(SEED), .LOCK_WORDS(LW), .ERR_CNT_WIDTH(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .data(data), .enable(enable), .data_error(data_error),
    .bypass(bypass), .err_count_clear(err_count_clear), .descrambledData(dd_s),
    .descrambled_valid(dv_s), .descrambled_error(de_s), .locked(lk_s), .err_count(err_count_s));

  always #5 clock = ~clock;

  int checks = 0, errors = 0;

  logic [57:0] tx_prev, e_dat;
  bit          m_hist, e_vld, e_err, e_lock, e_chk;
  int          m_good, m_cnt, m_cnt_s;

  function automatic logic [57:0] rnd58();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[57:0];
  endfunction

  // Transmit scrambler, one bit at a time over the serial stream history.
  function automatic logic [57:0] scramble(input logic [57:0] d, input logic [57:0] prev);
    logic [115:0] s;
    s[57:0] = prev;
    for (int n = 0; n < 58; n++) s[58+n] = d[n] ~^ s[58+n-39] ~^ s[58+n-58];
    return s[115:58];
  endfunction

  task automatic model_reset();
    tx_prev = SEED; m_hist = 0; m_good = 0; m_cnt = 0; m_cnt_s = 0;
    e_vld = 0; e_err = 0; e_lock = 0; e_chk = 1; e_dat = '0;
  endtask

  // Drives one cycle of input and advances the model; outputs sampled 1 after the edge.
  task automatic cyc(input bit en, input logic [57:0] pay, input bit de, input bit byp, input bit clr);
    logic [57:0] scr, sent;
    scr  = byp ? pay : scramble(pay, tx_prev);
    sent = scr;
    if (de && !byp) sent = scr ^ (58'(1) << $urandom_range(57, 0));
    enable = en; data = en ? sent : rnd58(); data_error = de; bypass = byp; err_count_clear = clr;
    if (en) begin
      tx_prev = scr;
      e_vld = 1;
      e_err = de | (!byp & !m_hist);
      m_hist = !de;
      e_dat = pay;
      e_chk = !e_err;
      if (e_err) m_good = 0;
      else if (!byp) m_good++;
      e_lock = (m_good >= LW);
    end else begin
      e_vld = 0;
    end
    if (clr) begin
      m_cnt = 0; m_cnt_s = 0;
    end else if (en && e_err) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 15) m_cnt_s++;
    end
    @(posedge clock); #1;
    enable = 0; data_error = 0; bypass = 0; err_count_clear = 0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({descrambledData, descrambled_valid, descrambled_error, locked, err_count, err_count_s} !== '0) begin
      errors++;
      $display("FAIL reset: got data=%h vld=%b err=%b lock=%b cnt=%0d cnt4=%0d want all zero",
               descrambledData, descrambled_valid, descrambled_error, locked, err_count, err_count_s);
    end
    @(negedge clock); reset_n = 1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 100; i++) begin
      cyc(1, rnd58(), 0, 0, 0);
      checks++;
      if ({descrambled_valid, descrambled_error, locked} !== {e_vld, e_err, e_lock} ||
          err_count !== 16'(m_cnt) || err_count_s !== 4'(m_cnt_s)) begin
        errors++;
        $display("FAIL stream word %0d: vld/err/lock/cnt/cnt4 got %b %b %b %0d %0d want %b %b %b %0d %0d", i,
                 descrambled_valid, descrambled_error, locked, err_count, err_count_s, e_vld, e_err, e_lock, m_cnt, m_cnt_s);
      end
      checks++;
      if (descrambledData !== e_dat) begin
        errors++;
        $display("FAIL stream data word %0d: got %h want %h", i, descrambledData, e_dat);
      end
    end
    checks++;
    if (err_count !== 16'd1) begin
      errors++;
      $display("FAIL stream err_count: got %0d want 1", err_count);
    end
  endtask

  task automatic test_data_error();
    int base = m_cnt;
    for (int i = 0; i < 12; i++) begin
      cyc(1, rnd58(), i == 3, 0, 0);
      checks++;
      if ({descrambled_valid, descrambled_error, locked} !== {e_vld, e_err, e_lock} ||
          err_count !== 16'(m_cnt) || err_count_s !== 4'(m_cnt_s)) begin
        errors++;
        $display("FAIL data_error word %0d: vld/err/lock/cnt got %b %b %b %0d want %b %b %b %0d", i,
                 descrambled_valid, descrambled_error, locked, err_count, e_vld, e_err, e_lock, m_cnt);
      end
      if (e_chk) begin
        checks++;
        if (descrambledData !== e_dat) begin
          errors++;
          $display("FAIL data_error data word %0d: got %h want %h", i, descrambledData, e_dat);
        end
      end
    end
    checks++;
    if (err_count !== 16'(base + 2)) begin
      errors++;
      $display("FAIL data_error err_count: got %0d want %0d", err_count, base + 2);
    end
  endtask

  task automatic test_gaps();
    int words = 0, idle = 0, cycles = 0;
    bit en;
    while (words < 60 && cycles < 2000) begin
      en = ($urandom_range(99, 0) < 30) || (idle >= 20);
      cyc(en, rnd58(), 0, 0, 0);
      cycles++;
      checks++;
      if ({descrambled_valid, descrambled_error, locked} !== {e_vld, e_err, e_lock} ||
          err_count !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL gaps cycle %0d: vld/err/lock/cnt got %b %b %b %0d want %b %b %b %0d", cycles,
                 descrambled_valid, descrambled_error, locked, err_count, e_vld, e_err, e_lock, m_cnt);
      end
      if (e_chk) begin
        checks++;
        if (descrambledData !== e_dat) begin
          errors++;
          $display("FAIL gaps data cycle %0d: got %h want %h", cycles, descrambledData, e_dat);
        end
      end
      if (en) begin words++; idle = 0; end else idle++;
    end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 20; i++) begin
      cyc(1, rnd58(), 0, i < 10, 0);
      checks++;
      if ({descrambled_valid, descrambled_error, locked} !== {e_vld, e_err, e_lock} ||
          err_count !== 16'(m_cnt) || descrambledData !== e_dat) begin
        errors++;
        $display("FAIL bypass word %0d: vld/err/lock got %b %b %b data %h want %b %b %b data %h", i,
                 descrambled_valid, descrambled_error, locked, descrambledData, e_vld, e_err, e_lock, e_dat);
      end
    end
  endtask

  task automatic test_saturate_clear();
    for (int i = 0; i < 20; i++) cyc(1, rnd58(), 1, 0, 0);
    checks++;
    if (err_count_s !== 4'd15 || err_count !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL saturate: cnt4 got %0d want 15, cnt got %0d want %0d", err_count_s, err_count, m_cnt);
    end
    cyc(1, rnd58(), 1, 0, 1);
    checks++;
    if (err_count_s !== 4'd0 || err_count !== 16'd0 || descrambled_error !== 1'b1) begin
      errors++;
      $display("FAIL clear: cnt4 got %0d cnt got %0d err %b want 0 0 1", err_count_s, err_count, descrambled_error);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) cyc(1, rnd58(), 0, 0, 0);
      #2 reset_n = 0;
      #1;
      checks++;
      if ({descrambledData, descrambled_valid, descrambled_error, locked, err_count} !== '0) begin
        errors++;
        $display("FAIL async_reset %0d: got data=%h vld=%b err=%b lock=%b cnt=%0d want all zero", k,
                 descrambledData, descrambled_valid, descrambled_error, locked, err_count);
      end
      model_reset();
      @(negedge clock); reset_n = 1;
      // First post-reset word: descrambled against seed; flagged unless bypassed.
      cyc(1, rnd58(), 0, k == 1, 0);
      checks++;
      if ({descrambled_valid, descrambled_error, locked} !== {e_vld, e_err, e_lock} ||
          descrambledData !== e_dat || err_count !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL post_reset %0d: vld/err/lock got %b %b %b data %h cnt %0d want %b %b %b data %h cnt %0d", k,
                 descrambled_valid, descrambled_error, locked, descrambledData, err_count, e_vld, e_err, e_lock, e_dat, m_cnt);
      end
      for (int i = 0; i < 6; i++) begin
        cyc(1, rnd58(), 0, 0, 0);
        checks++;
        if ({descrambled_error, locked} !== {e_err, e_lock} || descrambledData !== e_dat) begin
          errors++;
          $display("FAIL post_reset %0d word %0d: err/lock got %b %b data %h want %b %b data %h", k, i,
                   descrambled_error, locked, descrambledData, e_err, e_lock, e_dat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_data_error();
    test_gaps();
    test_bypass();
    test_saturate_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
